// File: rtl/fpu_pkg.sv
// Shared constants and helpers for the FP datapath.
// Mode encodings for the two's-complement unit and a stage-count helper.
package fpu_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_NEG  = 2'd1;
    localparam logic [1:0] MODE_ABS  = 2'd2;
    localparam logic [1:0] MODE_CNEG = 2'd3;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// One carry-lookahead adder slice: sum = x + y + ci, co = carry out.
// Each carry is a flat generate/propagate product, not a ripple.
module cla_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         acc;
    logic         pp;

    always_comb begin
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & ci);
        end
    end

    assign sum = p ^ c[W-1:0];
    assign co  = c[W];

endmodule

// File: rtl/twos_comp_pipe.sv
// Pipelined two's-complement negate/abs unit with valid/ready flow control.
// The +1 carry ripples across register stages, CPS chunks per stage.
module twos_comp_pipe
    import fpu_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int CHUNK = 4,
    parameter int CPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic             in_sign,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_ovf,
    output logic             out_neg
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int LAT = ceil_div(NCH, CPS);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("twos_comp_pipe: WIDTH must be a multiple of CHUNK");
    end

    logic [LAT-1:0]            v_q;
    logic [LAT-1:0]            carry_q;
    logic [LAT-1:0]            ovf_q;
    logic [LAT-1:0]            neg_q;
    logic [LAT-1:0][WIDTH-1:0] data_q;

    logic [LAT-1:0]            adv;
    logic [LAT-1:0]            cin;
    logic [LAT-1:0]            cout;
    logic [LAT-1:0]            v_in;
    logic [LAT-1:0]            ovf_in;
    logic [LAT-1:0]            neg_in;
    logic [LAT-1:0][WIDTH-1:0] st_in;
    logic [LAT-1:0][WIDTH-1:0] st_out;
    logic [NCH-1:0]            ci;
    logic [NCH-1:0]            co;

    logic do_neg;
    logic unused_final_carry;

    assign do_neg = (in_mode == MODE_NEG)
                  | ((in_mode == MODE_ABS) & in_x[WIDTH-1])
                  | ((in_mode == MODE_CNEG) & in_sign);

    // Carry out of the top chunk is the discarded wrap of the +1.
    assign unused_final_carry = carry_q[LAT-1];

    for (genvar t = 0; t < LAT; t++) begin : g_stage
        localparam int LO = t * CPS;
        localparam int HI = (((t + 1) * CPS < NCH) ? (t + 1) * CPS : NCH) - 1;

        if (t == 0) begin : g_head
            assign st_in[t] = do_neg ? ~in_x : in_x;
            assign cin[t]   = do_neg;
        end else begin : g_body
            assign st_in[t] = data_q[t-1];
            assign cin[t]   = carry_q[t-1];
        end

        assign cout[t] = co[HI];

        for (genvar j = 0; j < NCH; j++) begin : g_chunk
            if (j >= LO && j <= HI) begin : g_add
                if (j == LO) begin : g_first
                    assign ci[j] = cin[t];
                end else begin : g_chain
                    assign ci[j] = co[j-1];
                end

                cla_chunk #(
                    .W (CHUNK)
                ) u_cla (
                    .x   (st_in[t][j*CHUNK +: CHUNK]),
                    .y   ({CHUNK{1'b0}}),
                    .ci  (ci[j]),
                    .sum (st_out[t][j*CHUNK +: CHUNK]),
                    .co  (co[j])
                );
            end else begin : g_pass
                assign st_out[t][j*CHUNK +: CHUNK] = st_in[t][j*CHUNK +: CHUNK];
            end
        end
    end

    always_comb begin
        v_in      = '0;
        ovf_in    = '0;
        neg_in    = '0;
        v_in[0]   = in_valid;
        ovf_in[0] = do_neg & (in_x == MOST_NEG);
        neg_in[0] = do_neg;
        for (int t = 1; t < LAT; t++) begin
            v_in[t]   = v_q[t-1];
            ovf_in[t] = ovf_q[t-1];
            neg_in[t] = neg_q[t-1];
        end
    end

    // A stage moves when any slot from it to the output is free.
    always_comb begin
        adv = '0;
        for (int t = 0; t < LAT; t++) begin
            adv[t] = out_ready;
            for (int u = t; u < LAT; u++) begin
                adv[t] = adv[t] | ~v_q[u];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            neg_q   <= '0;
            data_q  <= '0;
        end else begin
            for (int t = 0; t < LAT; t++) begin
                if (adv[t]) begin
                    v_q[t]     <= v_in[t];
                    carry_q[t] <= cout[t];
                    ovf_q[t]   <= ovf_in[t];
                    neg_q[t]   <= neg_in[t];
                    data_q[t]  <= st_out[t];
                end
            end
            if (flush) begin
                v_q <= '0;
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[LAT-1];
    assign out_y     = data_q[LAT-1];
    assign out_ovf   = ovf_q[LAT-1];
    assign out_neg   = neg_q[LAT-1];

endmodule
